// File: rtl/vertex_loader.sv
// Serial-to-parallel feeder for the matrix-vector multiplier: loads a 4x4 matrix,
// then presents one complete vertex at a time behind an out_valid/out_ready handshake.
module vertex_loader #(
  parameter int WIDTH     = 16,
  parameter int MAT_WORDS = 16,
  parameter int VEC_WORDS = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [WIDTH-1:0]                    in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                mat_reload,
  output logic [MAT_WORDS-1:0][WIDTH-1:0]     a,
  output logic [VEC_WORDS-1:0][WIDTH-1:0]     b,
  output logic                                mat_valid,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [15:0]                         vtx_count
);

  localparam int CNT_W = $clog2(MAT_WORDS);

  typedef enum logic [1:0] {
    LOAD_MAT = 2'd0,
    LOAD_VTX = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t                                state_reg;
  logic [CNT_W-1:0]                      cnt_reg;
  logic                                  mat_valid_reg;
  logic                                  out_valid_reg;
  logic [15:0]                           vtx_count_reg;
  logic [MAT_WORDS-1:0][WIDTH-1:0]       a_reg;
  logic [VEC_WORDS-1:0][WIDTH-1:0]       b_reg;
  logic [VEC_WORDS-2:0][WIDTH-1:0]       vbuf_reg;

  logic take;
  logic mat_take;
  logic vtx_take;
  logic vtx_done;

  assign in_ready = !rst && (state_reg == LOAD_MAT || state_reg == LOAD_VTX);
  assign take     = in_valid && in_ready;
  // A reload in the same cycle wins: the word on the bus is dropped.
  assign mat_take = take && !mat_reload && (state_reg == LOAD_MAT);
  assign vtx_take = take && !mat_reload && (state_reg == LOAD_VTX);
  assign vtx_done = vtx_take && (cnt_reg == CNT_W'(VEC_WORDS - 1));

  assign a         = a_reg;
  assign b         = b_reg;
  assign mat_valid = mat_valid_reg;
  assign out_valid = out_valid_reg;
  assign vtx_count = vtx_count_reg;

  generate
    for (genvar gi = 0; gi < MAT_WORDS; gi++) begin : g_mat_word
      always_ff @(posedge clk) begin
        if (rst) begin
          a_reg[gi] <= '0;
        end else if (mat_take && cnt_reg == CNT_W'(gi)) begin
          a_reg[gi] <= in_data;
        end
      end
    end

    for (genvar gi = 0; gi < VEC_WORDS - 1; gi++) begin : g_vbuf_word
      always_ff @(posedge clk) begin
        if (rst) begin
          vbuf_reg[gi] <= '0;
        end else if (vtx_take && cnt_reg == CNT_W'(gi)) begin
          vbuf_reg[gi] <= in_data;
        end
      end
    end

    // The last vertex word bypasses the buffer so b updates in one edge.
    for (genvar gi = 0; gi < VEC_WORDS; gi++) begin : g_b_word
      if (gi == VEC_WORDS - 1) begin : g_last
        always_ff @(posedge clk) begin
          if (rst) begin
            b_reg[gi] <= '0;
          end else if (vtx_done) begin
            b_reg[gi] <= in_data;
          end
        end
      end else begin : g_buffered
        always_ff @(posedge clk) begin
          if (rst) begin
            b_reg[gi] <= '0;
          end else if (vtx_done) begin
            b_reg[gi] <= vbuf_reg[gi];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= LOAD_MAT;
      cnt_reg       <= '0;
      mat_valid_reg <= 1'b0;
      out_valid_reg <= 1'b0;
      vtx_count_reg <= '0;
    end else if (mat_reload) begin
      state_reg     <= LOAD_MAT;
      cnt_reg       <= '0;
      mat_valid_reg <= 1'b0;
      out_valid_reg <= 1'b0;
      vtx_count_reg <= '0;
    end else begin
      case (state_reg)
        LOAD_MAT: begin
          if (take) begin
            if (cnt_reg == CNT_W'(MAT_WORDS - 1)) begin
              state_reg     <= LOAD_VTX;
              mat_valid_reg <= 1'b1;
              cnt_reg       <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        LOAD_VTX: begin
          if (take) begin
            if (cnt_reg == CNT_W'(VEC_WORDS - 1)) begin
              state_reg     <= HOLD;
              out_valid_reg <= 1'b1;
              cnt_reg       <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_reg     <= LOAD_VTX;
            out_valid_reg <= 1'b0;
            vtx_count_reg <= vtx_count_reg + 16'd1;
          end
        end
        default: begin
          state_reg <= LOAD_MAT;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vertex_loader.sv
// Self-checking bench for vertex_loader: directed table, hand-written corner sequences,
// and randomized traffic against a word-stream reference model.
module tb_vertex_loader;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [15:0]             in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic                    mat_reload;
  logic [15:0][15:0]       a;
  logic [3:0][15:0]        b;
  logic                    mat_valid;
  logic                    out_valid;
  logic                    out_ready;
  logic [15:0]             vtx_count;

  always #5 clk = ~clk;

  vertex_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mat_reload (mat_reload),
    .a          (a),
    .b          (b),
    .mat_valid  (mat_valid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .vtx_count  (vtx_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: a matrix being filled word by word, a vertex being gathered,
  // and a pending flag meaning a delivered vertex waits for the consumer.
  logic [15:0] m_a [16];
  logic [15:0] m_b [4];
  logic [15:0] m_words [$];
  bit          m_filling_mat;
  bit          m_mat_valid;
  bit          m_pending;
  logic [15:0] m_count;
  int          delivered = 0;

  function automatic logic [255:0] model_a();
    logic [15:0][15:0] pa;
    for (int i = 0; i < 16; i++) pa[i] = m_a[i];
    return pa;
  endfunction

  function automatic logic [63:0] model_b();
    logic [3:0][15:0] pb;
    for (int i = 0; i < 4; i++) pb[i] = m_b[i];
    return pb;
  endfunction

  task automatic model_step();
    bit accepts;
    accepts = !rst && !m_pending;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_a[i] = 16'h0;
      for (int i = 0; i < 4; i++) m_b[i] = 16'h0;
      m_words.delete();
      m_filling_mat = 1;
      m_mat_valid   = 0;
      m_pending     = 0;
      m_count       = 16'h0;
    end else if (mat_reload) begin
      m_words.delete();
      m_filling_mat = 1;
      m_mat_valid   = 0;
      m_pending     = 0;
      m_count       = 16'h0;
    end else if (m_pending) begin
      if (out_ready) begin
        m_pending = 0;
        m_count   = m_count + 16'd1;
        delivered++;
        $display("vertex %0d consumed b=%h vtx_count=%0h", delivered, model_b(), m_count);
      end
    end else if (in_valid && accepts) begin
      if (m_filling_mat) begin
        m_a[m_words.size()] = in_data;
        m_words.push_back(in_data);
        if (m_words.size() == 16) begin
          m_words.delete();
          m_filling_mat = 0;
          m_mat_valid   = 1;
        end
      end else begin
        m_words.push_back(in_data);
        if (m_words.size() == 4) begin
          for (int i = 0; i < 4; i++) m_b[i] = m_words[i];
          m_words.delete();
          m_pending = 1;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_in_ready"},  {255'h0, in_ready},  {255'h0, (!rst && !m_pending)});
    chk({tag, "_mat_valid"}, {255'h0, mat_valid}, {255'h0, m_mat_valid});
    chk({tag, "_out_valid"}, {255'h0, out_valid}, {255'h0, m_pending});
    chk({tag, "_vtx_count"}, {240'h0, vtx_count}, {240'h0, m_count});
    chk({tag, "_a"}, a, model_a());
    chk({tag, "_b"}, {192'h0, b}, {192'h0, model_b()});
  endtask

  task automatic cycle(input logic r, input logic iv, input logic [15:0] d,
                       input logic ordy, input logic rl, input string tag);
    rst        = r;
    in_valid   = iv;
    in_data    = d;
    out_ready  = ordy;
    mat_reload = rl;
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic load_matrix(input logic [15:0] base, input string tag);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, base + 16'(i), 1'b0, 1'b0, tag);
  endtask

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    logic        exp_ov;
    logic        exp_ir;
    logic [15:0] exp_cnt;
    logic [63:0] exp_b;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [15:0][15:0] exp_a;
    logic [63:0]       bv;
    logic [63:0]       got_b [$];
    int                k;
    int                cyc;
    bit                tr;

    // Directed vertex scenario: 4 words, 10 stalled cycles, then consume.
    bv = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    tbl[0] = '{1'b1, 16'h000A, 1'b0, 1'b0, 1'b1, 16'h0, 64'h0};
    tbl[1] = '{1'b1, 16'h000B, 1'b0, 1'b0, 1'b1, 16'h0, 64'h0};
    tbl[2] = '{1'b1, 16'h000C, 1'b0, 1'b0, 1'b1, 16'h0, 64'h0};
    tbl[3] = '{1'b1, 16'h000D, 1'b0, 1'b1, 1'b0, 16'h0, bv};
    for (int i = 4; i < 14; i++) tbl[i] = '{1'b1, 16'h00EE, 1'b0, 1'b1, 1'b0, 16'h0, bv};
    tbl[14] = '{1'b1, 16'h00EE, 1'b1, 1'b0, 1'b1, 16'h1, bv};
    tbl[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1, bv};

    // Reset held 3 cycles with in_valid high.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, "reset");
      chk("reset_in_ready", {255'h0, in_ready}, 256'h0);
    end
    chk("reset_a", a, 256'h0);
    chk("reset_b", {192'h0, b}, 256'h0);
    chk("reset_count", {240'h0, vtx_count}, 256'h0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("release_in_ready", {255'h0, in_ready}, 256'h1);

    // Matrix load 0x0001..0x0010.
    for (int i = 0; i < 16; i++) begin
      chk("mat_valid_before_last", {255'h0, mat_valid}, 256'h0);
      cycle(1'b0, 1'b1, 16'(i + 1), 1'b0, 1'b0, "mat");
    end
    for (int i = 0; i < 16; i++) exp_a[i] = 16'(i + 1);
    chk("mat_a", a, exp_a);
    chk("mat_valid", {255'h0, mat_valid}, 256'h1);
    chk("mat_out_valid", {255'h0, out_valid}, 256'h0);

    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, tbl[i].iv, tbl[i].d, tbl[i].ordy, 1'b0, "tbl");
      chk($sformatf("tbl%0d_out_valid", i), {255'h0, out_valid}, {255'h0, tbl[i].exp_ov});
      chk($sformatf("tbl%0d_in_ready", i), {255'h0, in_ready}, {255'h0, tbl[i].exp_ir});
      chk($sformatf("tbl%0d_count", i), {240'h0, vtx_count}, {240'h0, tbl[i].exp_cnt});
      chk($sformatf("tbl%0d_b", i), {192'h0, b}, {192'h0, tbl[i].exp_b});
    end

    // Throughput with in_valid toggling and out_ready tied high.
    k   = 0;
    cyc = 0;
    while ((got_b.size() < 3 || out_valid) && cyc < 100) begin
      rst = 1'b0; mat_reload = 1'b0; out_ready = 1'b1;
      in_valid = (cyc % 2 == 0) && (k < 12);
      in_data  = 16'h0100 + 16'(k);
      #1;
      tr = in_valid && in_ready;
      cycle(1'b0, in_valid, in_data, 1'b1, 1'b0, "tput");
      if (tr) k++;
      if (out_valid) got_b.push_back(b);
      cyc++;
    end
    chk("tput_done", {224'h0, 32'(got_b.size())}, {224'h0, 32'd3});
    for (int v = 0; v < 3 && v < got_b.size(); v++)
      chk($sformatf("tput_b%0d", v), {192'h0, got_b[v]},
          {192'h0, 16'h0103 + 16'(4 * v), 16'h0102 + 16'(4 * v),
                   16'h0101 + 16'(4 * v), 16'h0100 + 16'(4 * v)});
    chk("tput_count", {240'h0, vtx_count}, {240'h0, 16'h4});

    // Reload with a simultaneous vertex word transfer.
    cycle(1'b0, 1'b1, 16'h0300, 1'b0, 1'b0, "rl1");
    cycle(1'b0, 1'b1, 16'h0301, 1'b0, 1'b1, "rl1");
    chk("rl1_mat_valid", {255'h0, mat_valid}, 256'h0);
    chk("rl1_count", {240'h0, vtx_count}, 256'h0);
    chk("rl1_in_ready", {255'h0, in_ready}, 256'h1);
    chk("rl1_a_kept", a, exp_a);
    load_matrix(16'h0200, "rl1_mat");
    for (int i = 0; i < 16; i++) exp_a[i] = 16'h0200 + 16'(i);
    chk("rl1_new_a", a, exp_a);
    chk("rl1_new_mat_valid", {255'h0, mat_valid}, 256'h1);

    // Reload with out_ready in HOLD.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 16'h0400 + 16'(i), 1'b0, 1'b0, "rl2");
    chk("rl2_out_valid", {255'h0, out_valid}, 256'h1);
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, "rl2");
    chk("rl2_count", {240'h0, vtx_count}, 256'h0);
    chk("rl2_out_valid_clr", {255'h0, out_valid}, 256'h0);
    chk("rl2_b_kept", {192'h0, b}, {192'h0, 64'h0403_0402_0401_0400});
    load_matrix(16'h0500, "rl2_mat");

    // Counter wrap: preload 0xFFFE, then deliver two vertices.
    force dut.vtx_count_reg = 16'hFFFE;
    #2;
    release dut.vtx_count_reg;
    m_count = 16'hFFFE;
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 16'h0600 + 16'(i), 1'b0, 1'b0, "wrap");
      cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, "wrap");
    end
    chk("wrap_count", {240'h0, vtx_count}, 256'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 399) == 0), ($urandom_range(0, 9) < 7), 16'($urandom),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
